// File: rtl/alu_1_pipe_if.sv
// Bus between the sub_action decoder, the per-container action ALU and PHV reassembly.
// The master drives actions and operands; the slave (alu_1_pipe) returns container results.
interface alu_1_pipe_if #(
   parameter int ACTION_LEN = 25,
   parameter int DATA_WIDTH = 48
);
   logic [ACTION_LEN-1:0] action_in;
   logic                  action_valid;
   logic [DATA_WIDTH-1:0] operand_1_in;
   logic [DATA_WIDTH-1:0] operand_2_in;
   logic                  stall_in;
   logic [DATA_WIDTH-1:0] container_out;
   logic                  container_out_valid;
   logic                  carry_out;

   modport master (
      output action_in, action_valid, operand_1_in, operand_2_in, stall_in,
      input  container_out, container_out_valid, carry_out
   );

   modport slave (
      input  action_in, action_valid, operand_1_in, operand_2_in, stall_in,
      output container_out, container_out_valid, carry_out
   );
endinterface

// File: rtl/alu_1_pipe.sv
// First-type RMT action ALU with immediates, logical ops, carry/borrow flag, stallable pipeline.
// Optional macro ALU_1_SAT_EN: saturating add/addi and clamping sub/subi.
module alu_1_pipe #(
   parameter int STAGE      = 0,
   parameter int ACTION_LEN = 25,
   parameter int DATA_WIDTH = 48,
   parameter int IMM_WIDTH  = 16,
   parameter int PIPE_DEPTH = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_1_pipe_if.slave   bus
);

   generate
      if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
         $error("alu_1_pipe: PIPE_DEPTH must be within 1..8");
      end
      if (IMM_WIDTH > DATA_WIDTH || IMM_WIDTH > ACTION_LEN - 4) begin : g_bad_imm
         $error("alu_1_pipe: IMM_WIDTH too wide for DATA_WIDTH or ACTION_LEN");
      end
      if (STAGE < 0) begin : g_bad_stage
         $error("alu_1_pipe: STAGE must be non-negative");
      end
   endgenerate

   logic [3:0]            opcode;
   logic [DATA_WIDTH-1:0] imm_ext;
   logic [DATA_WIDTH-1:0] rhs;
   logic [DATA_WIDTH:0]   sum_wide;
   logic [DATA_WIDTH:0]   diff_wide;
   logic                  do_add;
   logic                  do_sub;
   logic [DATA_WIDTH-1:0] result_d;
   logic                  carry_d;

   logic [DATA_WIDTH-1:0] data_q  [PIPE_DEPTH];
   logic                  carry_q [PIPE_DEPTH];
   logic                  valid_q [PIPE_DEPTH];

   // Stage-0 datapath: one shared adder and subtractor; the second operand is op2 or the immediate.
   // Bit DATA_WIDTH of the widened difference is the unsigned borrow.
   always_comb begin
      opcode    = bus.action_in[ACTION_LEN-1 -: 4];
      imm_ext   = DATA_WIDTH'(bus.action_in[IMM_WIDTH-1:0]);
      rhs       = bus.operand_2_in;
      do_add    = 1'b0;
      do_sub    = 1'b0;
      result_d  = bus.operand_1_in;
      carry_d   = 1'b0;
      case (opcode)
         4'b0001, 4'b1001: do_add = 1'b1;
         4'b0010, 4'b1010: do_sub = 1'b1;
         4'b0011: begin do_add = 1'b1; rhs = imm_ext; end
         4'b0100: begin do_sub = 1'b1; rhs = imm_ext; end
         4'b0101: result_d = bus.operand_1_in & bus.operand_2_in;
         4'b0110: result_d = bus.operand_1_in | bus.operand_2_in;
         4'b0111: result_d = bus.operand_1_in ^ bus.operand_2_in;
         4'b1000: result_d = imm_ext;
         default: result_d = bus.operand_1_in;
      endcase
      sum_wide  = {1'b0, bus.operand_1_in} + {1'b0, rhs};
      diff_wide = {1'b0, bus.operand_1_in} - {1'b0, rhs};
      if (do_add) begin
         result_d = sum_wide[DATA_WIDTH-1:0];
         carry_d  = sum_wide[DATA_WIDTH];
`ifdef ALU_1_SAT_EN
         if (carry_d) result_d = '1;
`endif
      end else if (do_sub) begin
         result_d = diff_wide[DATA_WIDTH-1:0];
         carry_d  = diff_wide[DATA_WIDTH];
`ifdef ALU_1_SAT_EN
         if (carry_d) result_d = '0;
`endif
      end
      if (!bus.action_valid) begin
         result_d = '0;
         carry_d  = 1'b0;
      end
   end

   // Invalid slots are registered as all-zero so downstream can OR-combine containers.
   // A stall freezes every stage, including the outputs, and leaves the inputs unsampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            data_q[i]  <= '0;
            carry_q[i] <= 1'b0;
            valid_q[i] <= 1'b0;
         end
      end else if (!bus.stall_in) begin
         data_q[0]  <= result_d;
         carry_q[0] <= carry_d;
         valid_q[0] <= bus.action_valid;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            data_q[i]  <= data_q[i-1];
            carry_q[i] <= carry_q[i-1];
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   assign bus.container_out       = data_q[PIPE_DEPTH-1];
   assign bus.carry_out           = carry_q[PIPE_DEPTH-1];
   assign bus.container_out_valid = valid_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_alu_1_pipe.sv
// Self-checking bench for alu_1_pipe: three instances (PIPE_DEPTH 1, 3, 8) share one stimulus
// stream and are compared every cycle against a slot-history reference model.
module tb_alu_1_pipe;

   localparam int AL = 25;
   localparam int DW = 48;
   localparam int NDUT = 3;
   localparam int DEP [NDUT] = '{1, 3, 8};
   localparam logic [DW-1:0] ONES = {DW{1'b1}};

   typedef struct packed {
      logic          v;
      logic          c;
      logic [DW-1:0] d;
   } slot_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [AL-1:0] action = '0;
   logic          valid = 1'b0;
   logic [DW-1:0] op1 = '0;
   logic [DW-1:0] op2 = '0;
   logic          stall = 1'b0;

   int checks = 0;
   int errors = 0;

   slot_t hist [$];

   alu_1_pipe_if #(.ACTION_LEN(AL), .DATA_WIDTH(DW)) if_d1 ();
   alu_1_pipe_if #(.ACTION_LEN(AL), .DATA_WIDTH(DW)) if_d3 ();
   alu_1_pipe_if #(.ACTION_LEN(AL), .DATA_WIDTH(DW)) if_d8 ();

   assign if_d1.action_in = action;  assign if_d1.action_valid = valid;
   assign if_d1.operand_1_in = op1;  assign if_d1.operand_2_in = op2;  assign if_d1.stall_in = stall;
   assign if_d3.action_in = action;  assign if_d3.action_valid = valid;
   assign if_d3.operand_1_in = op1;  assign if_d3.operand_2_in = op2;  assign if_d3.stall_in = stall;
   assign if_d8.action_in = action;  assign if_d8.action_valid = valid;
   assign if_d8.operand_1_in = op1;  assign if_d8.operand_2_in = op2;  assign if_d8.stall_in = stall;

   alu_1_pipe #(.STAGE(0), .ACTION_LEN(AL), .DATA_WIDTH(DW), .IMM_WIDTH(16), .PIPE_DEPTH(1))
      dut_d1 (.clk(clk), .rst_n(rst_n), .bus(if_d1));
   alu_1_pipe #(.STAGE(1), .ACTION_LEN(AL), .DATA_WIDTH(DW), .IMM_WIDTH(16), .PIPE_DEPTH(3))
      dut_d3 (.clk(clk), .rst_n(rst_n), .bus(if_d3));
   alu_1_pipe #(.STAGE(2), .ACTION_LEN(AL), .DATA_WIDTH(DW), .IMM_WIDTH(16), .PIPE_DEPTH(8))
      dut_d8 (.clk(clk), .rst_n(rst_n), .bus(if_d8));

   slot_t obs [NDUT];
   assign obs[0] = {if_d1.container_out_valid, if_d1.carry_out, if_d1.container_out};
   assign obs[1] = {if_d3.container_out_valid, if_d3.carry_out, if_d3.container_out};
   assign obs[2] = {if_d8.container_out_valid, if_d8.carry_out, if_d8.container_out};

   always #5 clk = ~clk;

   // Reference ALU written directly from the op table with plain arithmetic.
   function automatic slot_t ref_alu(logic [AL-1:0] act, logic [DW-1:0] a, logic [DW-1:0] b, logic vld);
      slot_t s;
      logic [DW-1:0] imm;
      logic [DW:0]   full;
      s = '0;
      if (!vld) return s;
      s.v = 1'b1;
      imm = {32'h0, act[15:0]};
      case (act[AL-1:AL-4])
         4'd1, 4'd9, 4'd3: begin
            if (act[AL-1:AL-4] == 4'd3) b = imm;
            full = a + b;
            s.c = (full > {1'b0, ONES});
            s.d = full[DW-1:0];
`ifdef ALU_1_SAT_EN
            if (s.c) s.d = ONES;
`endif
         end
         4'd2, 4'd10, 4'd4: begin
            if (act[AL-1:AL-4] == 4'd4) b = imm;
            s.c = (a < b);
            s.d = a - b;
`ifdef ALU_1_SAT_EN
            if (s.c) s.d = '0;
`endif
         end
         4'd5: s.d = a & b;
         4'd6: s.d = a | b;
         4'd7: s.d = a ^ b;
         4'd8: s.d = imm;
         default: s.d = a;
      endcase
      return s;
   endfunction

   // Output of a depth-D pipeline is the slot accepted D-1 non-stalled edges before the latest one.
   function automatic slot_t model_out(int k);
      if (hist.size() >= DEP[k]) return hist[hist.size() - DEP[k]];
      return '0;
   endfunction

   function automatic logic [AL-1:0] mk_act(logic [3:0] opc, logic [15:0] imm);
      return {opc, 5'b0, imm};
   endfunction

   function automatic logic [DW-1:0] rnd48();
      return DW'({$urandom(), $urandom()});
   endfunction

   // Drives one cycle of inputs, advances the model on a non-stalled edge and returns at the negedge.
   task automatic applyStimulus(logic v, logic [3:0] opc, logic [15:0] imm,
                                logic [DW-1:0] a, logic [DW-1:0] b, logic st);
      valid = v; action = mk_act(opc, imm); op1 = a; op2 = b; stall = st;
      @(posedge clk);
      if (rst_n && !st) begin
         hist.push_back(ref_alu(mk_act(opc, imm), a, b, v));
         if (hist.size() > 8) void'(hist.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int k = 0; k < NDUT; k++) begin
         checks++;
         if (obs[k] !== slot_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_state depth%0d: got %h want 0", DEP[k], obs[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (cyc == 0) applyStimulus(1'b1, 4'd1, 16'h0, 48'd5, 48'd7, 1'b0);
         else          applyStimulus(1'b0, 4'd0, 16'h0, '0, '0, 1'b0);
         checks++;
         if (obs[1] !== ((cyc == 2) ? {1'b1, 1'b0, 48'd12} : slot_t'(0))) begin
            errors++;
            $display("[TB] FAIL first_result_d3 cyc%0d: got %h", cyc, obs[1]);
         end
         for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs[k] !== model_out(k)) begin
               errors++;
               $display("[TB] FAIL latency depth%0d cyc%0d: got %h want %h", DEP[k], cyc, obs[k], model_out(k));
            end
         end
      end
   endtask

   task automatic test_arith_imm();
      logic [3:0]    opc [4] = '{4'd1, 4'd4, 4'd8, 4'd2};
      logic [15:0]   imm [4] = '{16'h0, 16'h5, 16'hBEEF, 16'h0};
      logic [DW-1:0] a   [4] = '{ONES, 48'd3, 48'd99, 48'd10};
      logic [DW-1:0] b   [4] = '{48'd2, 48'd0, 48'd0, 48'd10};
`ifdef ALU_1_SAT_EN
      slot_t want [4] = '{{1'b1, 1'b1, ONES}, {1'b1, 1'b1, 48'd0}, {1'b1, 1'b0, 48'hBEEF}, {1'b1, 1'b0, 48'd0}};
`else
      slot_t want [4] = '{{1'b1, 1'b1, 48'd1}, {1'b1, 1'b1, 48'hFFFF_FFFF_FFFE}, {1'b1, 1'b0, 48'hBEEF}, {1'b1, 1'b0, 48'd0}};
`endif
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc < 4) applyStimulus(1'b1, opc[cyc], imm[cyc], a[cyc], b[cyc], 1'b0);
         else         applyStimulus(1'b0, 4'd0, 16'h0, '0, '0, 1'b0);
         if (cyc >= 2 && cyc < 6) begin
            checks++;
            if (obs[1] !== want[cyc-2]) begin
               errors++;
               $display("[TB] FAIL arith_imm item%0d: got %h want %h", cyc-2, obs[1], want[cyc-2]);
            end
         end
         for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs[k] !== model_out(k)) begin
               errors++;
               $display("[TB] FAIL arith_model depth%0d cyc%0d: got %h want %h", DEP[k], cyc, obs[k], model_out(k));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]    opc  [5] = '{4'd5, 4'd6, 4'd7, 4'd15, 4'd5};
      logic          vld  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [DW-1:0] want [5] = '{48'h30, 48'hFC, 48'hCC, 48'hF0, 48'h0};
      for (int cyc = 0; cyc < 13; cyc++) begin
         if (cyc < 5) applyStimulus(vld[cyc], opc[cyc], 16'h1234, 48'hF0, 48'h3C, 1'b0);
         else         applyStimulus(1'b0, 4'd0, 16'h0, '0, '0, 1'b0);
         if (cyc >= 2 && cyc < 7) begin
            checks++;
            if (obs[1] !== {vld[cyc-2], 1'b0, want[cyc-2]}) begin
               errors++;
               $display("[TB] FAIL stream item%0d: got %h want d=%h v=%0b", cyc-2, obs[1], want[cyc-2], vld[cyc-2]);
            end
         end
         for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs[k] !== model_out(k)) begin
               errors++;
               $display("[TB] FAIL stream_model depth%0d cyc%0d: got %h want %h", DEP[k], cyc, obs[k], model_out(k));
            end
         end
      end
   endtask

   task automatic test_stall();
      int seen3;
      seen3 = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (cyc < 3)       applyStimulus(1'b1, 4'd1, 16'h0, 48'd0, DW'(cyc + 1), 1'b0);
         else if (cyc == 3) applyStimulus(1'b0, 4'd0, 16'h0, '0, '0, 1'b0);
         else if (cyc < 8)  applyStimulus(1'b1, 4'd1, 16'h0, 48'd0, 48'd50, 1'b1);
         else               applyStimulus(1'b0, 4'd0, 16'h0, '0, '0, 1'b0);
         if (cyc >= 3 && cyc < 8) begin
            checks++;
            if (obs[1] !== {1'b1, 1'b0, 48'd2}) begin
               errors++;
               $display("[TB] FAIL stall_hold cyc%0d: got %h want d=2 v=1", cyc, obs[1]);
            end
         end
         if (obs[1].v && obs[1].d == 48'd3) seen3++;
         for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs[k] !== model_out(k)) begin
               errors++;
               $display("[TB] FAIL stall_model depth%0d cyc%0d: got %h want %h", DEP[k], cyc, obs[k], model_out(k));
            end
         end
      end
      checks++;
      if (seen3 != 1) begin
         errors++;
         $display("[TB] FAIL stall_result3_count: got %0d want 1", seen3);
      end
   endtask

   task automatic test_async_reset();
      for (int cyc = 0; cyc < 3; cyc++) applyStimulus(1'b1, 4'd6, 16'h0, rnd48(), rnd48(), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         checks++;
         if (obs[k] !== slot_t'(0)) begin
            errors++;
            $display("[TB] FAIL async_reset depth%0d: got %h want 0", DEP[k], obs[k]);
         end
      end
      hist.delete();
      applyStimulus(1'b1, 4'd1, 16'h0, 48'd1, 48'd1, 1'b1);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         applyStimulus(1'b0, 4'd0, 16'h0, '0, '0, 1'b0);
         for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs[k] !== slot_t'(0)) begin
               errors++;
               $display("[TB] FAIL post_reset_stale depth%0d cyc%0d: got %h want 0", DEP[k], cyc, obs[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 16'($urandom()),
                       ($urandom_range(0, 3) == 0) ? ONES : rnd48(), rnd48(), $urandom_range(0, 4) == 0);
         for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs[k] !== model_out(k)) begin
               errors++;
               $display("[TB] FAIL random depth%0d cyc%0d: got %h want %h", DEP[k], cyc, obs[k], model_out(k));
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_arith_imm();
      test_back_to_back();
      test_stall();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
